// File: rtl/toy_pack.sv
// toy_pack: shared widths and the icache responder slot state encoding
package toy_pack;
    localparam int ADDR_WIDTH = 32;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int ROB_ENTRY_ID_WIDTH = 4;
    localparam int ICS_OST_DEPTH = 4;
    typedef enum logic [1:0] {ICS_FREE, ICS_PEND, ICS_ISSUED, ICS_DONE} toy_ics_state_e;
endpackage

// File: rtl/toy_bpu_icache_resp_slot.sv
// toy_bpu_icache_resp_slot: one outstanding fetch slot (state, pc, entry id, data)
module toy_bpu_icache_resp_slot
    import toy_pack::*;
#(
    parameter int ROB_PTR_WIDTH = ROB_ENTRY_ID_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc,
    input  logic [ADDR_WIDTH-1:0]       req_pc,
    input  logic [ROB_PTR_WIDTH-1:0]    req_entry_id,
    input  logic                        issue,
    input  logic                        rsp_vld,
    input  logic [FETCH_DATA_WIDTH-1:0] rsp_data,
    input  logic                        flush,
    input  logic                        free_en,
    output toy_ics_state_e              state,
    output logic [ADDR_WIDTH-1:0]       pc,
    output logic [ROB_PTR_WIDTH-1:0]    entry_id,
    output logic [FETCH_DATA_WIDTH-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ICS_FREE;
            pc       <= '0;
            entry_id <= '0;
            data     <= '0;
        end else if (state == ICS_FREE && alloc) begin
            state    <= ICS_PEND;
            pc       <= req_pc;
            entry_id <= req_entry_id;
        end else if (state == ICS_PEND && issue) begin
            state <= ICS_ISSUED;
        end else if (state == ICS_PEND && flush) begin
            state <= ICS_DONE;
            data  <= '0;
        end else if (state == ICS_ISSUED && rsp_vld) begin
            state <= ICS_DONE;
            data  <= rsp_data;
        end else if (state == ICS_DONE && free_en) begin
            state <= ICS_FREE;
        end
    end
endmodule

// File: rtl/toy_bpu_icache_resp.sv
// toy_bpu_icache_resp: fetch request responder with tagged out-of-order memory and flush drain
module toy_bpu_icache_resp
    import toy_pack::*;
#(
    parameter int   ROB_PTR_WIDTH = ROB_ENTRY_ID_WIDTH,
    parameter int   OST_DEPTH     = ICS_OST_DEPTH,
    localparam int  TAG_WIDTH     = $clog2(OST_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_req_vld,
    output logic                        fetch_req_rdy,
    input  logic [ADDR_WIDTH-1:0]       fetch_req_pc,
    input  logic [ROB_PTR_WIDTH-1:0]    fetch_req_entry_id,
    output logic                        mem_req_vld,
    input  logic                        mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    output logic [TAG_WIDTH-1:0]        mem_req_tag,
    input  logic                        mem_rsp_vld,
    input  logic [TAG_WIDTH-1:0]        mem_rsp_tag,
    input  logic [FETCH_DATA_WIDTH-1:0] mem_rsp_data,
    output logic                        icache_ack_vld,
    input  logic                        icache_ack_rdy,
    output logic [FETCH_DATA_WIDTH-1:0] icache_ack_pld,
    output logic [ROB_PTR_WIDTH-1:0]    icache_ack_entry_id,
    input  logic                        fe_ctrl_flush,
    output logic                        idle
);
    toy_ics_state_e              st        [OST_DEPTH];
    logic [ADDR_WIDTH-1:0]       slot_pc   [OST_DEPTH];
    logic [ROB_PTR_WIDTH-1:0]    slot_id   [OST_DEPTH];
    logic [FETCH_DATA_WIDTH-1:0] slot_data [OST_DEPTH];
    logic [TAG_WIDTH-1:0]        fifo      [OST_DEPTH];
    logic [TAG_WIDTH:0]          wr_ptr, rd_ptr;
    logic [TAG_WIDTH-1:0]        alloc_idx, done_idx, head;
    logic                        any_free, any_done, all_free, accept, issue, ack_load;

    always_comb begin
        any_free  = 1'b0;
        any_done  = 1'b0;
        all_free  = 1'b1;
        alloc_idx = '0;
        done_idx  = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            all_free = all_free && st[i] == ICS_FREE;
            if (st[i] == ICS_FREE) begin
                any_free  = 1'b1;
                alloc_idx = TAG_WIDTH'(i);
            end
            if (st[i] == ICS_DONE) begin
                any_done = 1'b1;
                done_idx = TAG_WIDTH'(i);
            end
        end
    end

    assign head          = fifo[rd_ptr[TAG_WIDTH-1:0]];
    assign fetch_req_rdy = any_free;
    assign accept        = fetch_req_vld && any_free;
    assign mem_req_vld   = wr_ptr != rd_ptr;
    assign mem_req_addr  = slot_pc[head];
    assign mem_req_tag   = head;
    assign issue         = mem_req_vld && mem_req_rdy;
    assign ack_load      = (!icache_ack_vld || icache_ack_rdy) && any_done;
    assign idle          = all_free && !icache_ack_vld;

    for (genvar g = 0; g < OST_DEPTH; g++) begin : g_slot
        toy_bpu_icache_resp_slot #(.ROB_PTR_WIDTH(ROB_PTR_WIDTH)) u_slot (
            .clk          (clk),
            .rst          (rst),
            .alloc        (accept && alloc_idx == TAG_WIDTH'(g)),
            .req_pc       (fetch_req_pc),
            .req_entry_id (fetch_req_entry_id),
            .issue        (issue && head == TAG_WIDTH'(g)),
            .rsp_vld      (mem_rsp_vld && mem_rsp_tag == TAG_WIDTH'(g)),
            .rsp_data     (mem_rsp_data),
            .flush        (fe_ctrl_flush),
            .free_en      (ack_load && done_idx == TAG_WIDTH'(g)),
            .state        (st[g]),
            .pc           (slot_pc[g]),
            .entry_id     (slot_id[g]),
            .data         (slot_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo[wr_ptr[TAG_WIDTH-1:0]] <= alloc_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fe_ctrl_flush)
                rd_ptr <= wr_ptr;
            else if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icache_ack_vld      <= 1'b0;
            icache_ack_pld      <= '0;
            icache_ack_entry_id <= '0;
        end else if (!icache_ack_vld || icache_ack_rdy) begin
            icache_ack_vld <= any_done;
            if (any_done) begin
                icache_ack_pld      <= slot_data[done_idx];
                icache_ack_entry_id <= slot_id[done_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_rsp_vld)
            assert (st[mem_rsp_tag] inside {ICS_FREE, ICS_ISSUED});
    end
endmodule

// File: tb/tb_toy_bpu_icache_resp.sv
// tb_toy_bpu_icache_resp: directed and random checks against a transaction-level scoreboard
module tb_toy_bpu_icache_resp;
    import toy_pack::*;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = FETCH_DATA_WIDTH;
    localparam int IW = ROB_ENTRY_ID_WIDTH;
    localparam int TW = $clog2(ICS_OST_DEPTH);

    logic          clk = 1'b0, rst = 1'b1;
    logic          fetch_req_vld = 1'b0, fetch_req_rdy;
    logic [AW-1:0] fetch_req_pc = '0;
    logic [IW-1:0] fetch_req_entry_id = '0;
    logic          mem_req_vld, mem_req_rdy = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_rsp_vld = 1'b0;
    logic [TW-1:0] mem_rsp_tag = '0;
    logic [DW-1:0] mem_rsp_data = '0;
    logic          icache_ack_vld, icache_ack_rdy = 1'b0;
    logic [DW-1:0] icache_ack_pld;
    logic [IW-1:0] icache_ack_entry_id;
    logic          fe_ctrl_flush = 1'b0, idle;

    toy_bpu_icache_resp dut (
        .clk(clk), .rst(rst),
        .fetch_req_vld(fetch_req_vld), .fetch_req_rdy(fetch_req_rdy),
        .fetch_req_pc(fetch_req_pc), .fetch_req_entry_id(fetch_req_entry_id),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .icache_ack_vld(icache_ack_vld), .icache_ack_rdy(icache_ack_rdy),
        .icache_ack_pld(icache_ack_pld), .icache_ack_entry_id(icache_ack_entry_id),
        .fe_ctrl_flush(fe_ctrl_flush), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] id; } req_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] d; } ack_t;

    int            vectors = 0, miscompares = 0;
    req_t          iq[$];
    ack_t          exp_q[$], ack_log[$];
    logic [IW-1:0] mem_id[ICS_OST_DEPTH];
    bit            mem_busy[ICS_OST_DEPTH];
    int            accepted = 0, fired = 0, n_issue = 0;
    bit            hold = 1'b0;
    logic [DW-1:0] hold_pld;
    logic [IW-1:0] hold_id;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int occ, idx;
        occ = accepted - fired - int'(icache_ack_vld);
        check("rdy", fetch_req_rdy, occ < ICS_OST_DEPTH);
        check("idle", idle, occ == 0 && !icache_ack_vld);
        check("mem_vld", mem_req_vld, iq.size() != 0);
        if (hold) begin
            check("hold_vld", icache_ack_vld, 1);
            check("hold_pld", icache_ack_pld, hold_pld);
            check("hold_id", icache_ack_entry_id, hold_id);
        end
        if (mem_req_vld && iq.size() != 0)
            check("mem_addr", mem_req_addr, iq[0].pc);
        if (mem_req_vld && mem_req_rdy && iq.size() != 0) begin
            check("tag_unused", mem_busy[mem_req_tag], 0);
            mem_busy[mem_req_tag] = 1'b1;
            mem_id[mem_req_tag] = iq[0].id;
            void'(iq.pop_front());
            n_issue++;
        end
        if (mem_rsp_vld && mem_busy[mem_rsp_tag]) begin
            exp_q.push_back(ack_t'{id: mem_id[mem_rsp_tag], d: mem_rsp_data});
            mem_busy[mem_rsp_tag] = 1'b0;
        end
        if (fe_ctrl_flush) begin
            foreach (iq[i]) exp_q.push_back(ack_t'{id: iq[i].id, d: '0});
            iq.delete();
        end
        if (fetch_req_vld && fetch_req_rdy) begin
            iq.push_back(req_t'{pc: fetch_req_pc, id: fetch_req_entry_id});
            accepted++;
        end
        if (icache_ack_vld && icache_ack_rdy) begin
            idx = -1;
            foreach (exp_q[i])
                if (idx < 0 && exp_q[i].id == icache_ack_entry_id && exp_q[i].d == icache_ack_pld) idx = i;
            check("ack_expected", idx >= 0, 1);
            if (idx >= 0) exp_q.delete(idx);
            ack_log.push_back(ack_t'{id: icache_ack_entry_id, d: icache_ack_pld});
            fired++;
        end
        hold = icache_ack_vld && !icache_ack_rdy;
        hold_pld = icache_ack_pld;
        hold_id = icache_ack_entry_id;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [AW-1:0] pc, input logic [IW-1:0] id);
        int n = 0;
        fetch_req_vld = 1'b1;
        fetch_req_pc = pc;
        fetch_req_entry_id = id;
        while (!fetch_req_rdy && n < 100) begin
            tick();
            n++;
        end
        check("send_timeout", n < 100, 1);
        tick();
        fetch_req_vld = 1'b0;
    endtask

    function automatic int tag_of(input logic [IW-1:0] id);
        for (int i = 0; i < ICS_OST_DEPTH; i++)
            if (mem_busy[i] && mem_id[i] == id) return i;
        return -1;
    endfunction

    task automatic rsp(input logic [IW-1:0] id, input logic [DW-1:0] d);
        int t = tag_of(id);
        check("rsp_tag_found", t >= 0, 1);
        if (t >= 0) begin
            mem_rsp_vld = 1'b1;
            mem_rsp_tag = TW'(t);
            mem_rsp_data = d;
            tick();
            mem_rsp_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        iq.delete();
        exp_q.delete();
        foreach (mem_busy[i]) mem_busy[i] = 1'b0;
        accepted = 0;
        fired = 0;
        hold = 1'b0;
        check("rst_rdy", fetch_req_rdy, 1);
        check("rst_mem_vld", mem_req_vld, 0);
        check("rst_ack_vld", icache_ack_vld, 0);
        check("rst_ack_pld", icache_ack_pld, 0);
        check("rst_ack_id", icache_ack_entry_id, 0);
        check("rst_idle", idle, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ord[4] = '{2, 0, 3, 1};
        int n0, stale;
        int busy[$];
        do_reset();

        // single request, minimum latency
        mem_req_rdy = 1'b1;
        icache_ack_rdy = 1'b1;
        send(32'h1000, 3);
        tick();
        rsp(3, 32'hCAFE_F00D);
        check("lat_cycle1", icache_ack_vld, 0);
        tick();
        check("lat_cycle2", icache_ack_vld, 1);
        run(2);
        check("t1_count", ack_log.size(), 1);
        check("t1_id", ack_log[0].id, 3);
        check("t1_pld", ack_log[0].d, 32'hCAFE_F00D);
        check("t1_idle", idle, 1);

        // four requests, out-of-order responses
        ack_log.delete();
        for (int k = 0; k < 4; k++) send(32'h2000 + 32'(k * 16), IW'(k));
        check("full_rdy", fetch_req_rdy, 0);
        tick();
        for (int k = 0; k < 4; k++) check("alloc_slot", tag_of(IW'(k)), k);
        for (int k = 0; k < 4; k++) rsp(IW'(ord[k]), 32'hA000 + 32'(ord[k]));
        run(4);
        check("t2_count", ack_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_order_id", ack_log[k].id, ord[k]);
            check("t2_order_pld", ack_log[k].d, 32'hA000 + 32'(ord[k]));
        end
        check("t2_rdy_back", fetch_req_rdy, 1);

        // ack backpressure then back-to-back drain
        ack_log.delete();
        icache_ack_rdy = 1'b0;
        send(32'h3000, 4);
        send(32'h3010, 5);
        tick();
        rsp(4, 32'hB4);
        rsp(5, 32'hB5);
        run(2);
        n0 = int'(icache_ack_pld);
        for (int k = 0; k < 5; k++) begin
            check("stall_vld", icache_ack_vld, 1);
            check("stall_pld", icache_ack_pld, 32'(n0));
            tick();
        end
        icache_ack_rdy = 1'b1;
        check("b2b_first", icache_ack_vld, 1);
        tick();
        check("b2b_second", icache_ack_vld, 1);
        tick();
        check("b2b_done", icache_ack_vld, 0);
        check("t3_count", ack_log.size(), 2);
        check("t3_id0", ack_log[0].id, 4);
        check("t3_id1", ack_log[1].id, 5);

        // flush with nothing issued
        ack_log.delete();
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 3; k++) send(32'h4000 + 32'(k * 4), IW'(8 + k));
        check("pre_flush_vld", mem_req_vld, 1);
        fe_ctrl_flush = 1'b1;
        tick();
        fe_ctrl_flush = 1'b0;
        check("withdraw", mem_req_vld, 0);
        mem_req_rdy = 1'b1;
        n0 = n_issue;
        run(6);
        check("no_mem_req", n_issue, n0);
        check("t4_count", ack_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("t4_id", ack_log[k].id, 8 + k);
            check("t4_zero", ack_log[k].d, 0);
        end

        // flush with mixed issued/pending and a same-cycle new request
        ack_log.delete();
        icache_ack_rdy = 1'b0;
        send(32'h5000, 11);
        send(32'h5010, 12);
        tick();
        mem_req_rdy = 1'b0;
        send(32'h5020, 13);
        send(32'h5030, 14);
        check("t5_full", fetch_req_rdy, 0);
        rsp(11, 32'hC11);
        run(1);
        check("t5_rdy_freed", fetch_req_rdy, 1);
        fetch_req_vld = 1'b1;
        fetch_req_pc = 32'h7700;
        fetch_req_entry_id = 7;
        fe_ctrl_flush = 1'b1;
        tick();
        fetch_req_vld = 1'b0;
        fe_ctrl_flush = 1'b0;
        check("post_flush_vld", mem_req_vld, 1);
        check("post_flush_addr", mem_req_addr, 32'h7700);
        mem_req_rdy = 1'b1;
        tick();
        rsp(12, 32'hC12);
        rsp(7, 32'hC7);
        icache_ack_rdy = 1'b1;
        run(10);
        check("t5_count", ack_log.size(), 5);
        check("t5_first", ack_log[0].id, 11);
        check("t5_drained", exp_q.size(), 0);

        // reset mid-operation, stale response afterwards
        ack_log.delete();
        send(32'h6000, 1);
        send(32'h6010, 2);
        send(32'h6020, 3);
        stale = tag_of(1);
        check("t6_issued", stale >= 0, 1);
        do_reset();
        mem_rsp_vld = 1'b1;
        mem_rsp_tag = TW'(stale);
        mem_rsp_data = 32'hDEAD;
        tick();
        mem_rsp_vld = 1'b0;
        run(5);
        check("stale_no_ack", ack_log.size(), 0);
        check("stale_idle", idle, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fetch_req_vld = $urandom_range(99) < 55;
            fetch_req_pc = $urandom;
            fetch_req_entry_id = IW'($urandom);
            mem_req_rdy = $urandom_range(99) < 70;
            icache_ack_rdy = $urandom_range(99) < 70;
            fe_ctrl_flush = $urandom_range(99) < 3;
            busy.delete();
            foreach (mem_busy[i]) if (mem_busy[i]) busy.push_back(i);
            mem_rsp_vld = busy.size() != 0 && $urandom_range(1) == 1;
            mem_rsp_tag = busy.size() != 0 ? TW'(busy[$urandom_range(busy.size() - 1)]) : '0;
            mem_rsp_data = $urandom;
            tick();
        end
        fetch_req_vld = 1'b0;
        fe_ctrl_flush = 1'b0;
        mem_req_rdy = 1'b1;
        icache_ack_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            busy.delete();
            foreach (mem_busy[i]) if (mem_busy[i]) busy.push_back(i);
            mem_rsp_vld = busy.size() != 0;
            mem_rsp_tag = busy.size() != 0 ? TW'(busy[0]) : '0;
            mem_rsp_data = $urandom;
            if (busy.size() == 0 && iq.size() == 0 && exp_q.size() == 0 && idle) break;
            tick();
        end
        mem_rsp_vld = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
